turn_timer_ctrl: RTL

- Two-player turn-timer controller that sequences the on-screen digit renderer.
- Owns a per-turn countdown: 1 s prescaler, down-counter and turn state machine.
- Drives the renderer's Numero, RojoA and RojoB inputs; the renderer draws the digit and highlights the active player's field in red.
- Sits between the PS/2 key decode (Start/Jugada/Pausa pulses) and the VGA digit renderer, in the pixel clock domain.

---
 rtl/turn_timer_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/turn_timer_ctrl.sv
// Two-player turn timer: 1 s prescaler, per-turn seconds countdown and turn FSM driving the digit renderer.
// Latency: every output is registered one cycle after the state/counter update it reflects.
// Backpressure: none; Start/Jugada are single-cycle pulses, Pausa is a level that freezes the countdown.
module turn_timer_ctrl #(
  parameter int TICK_DIV = 25000000,
  parameter int INIT_SEC = 9
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Jugada,
  input  logic       Pausa,
  output logic [3:0] Numero,
  output logic       RojoA,
  output logic       RojoB,
  output logic       TimeoutA,
  output logic       TimeoutB,
  output logic       Busy
);

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]    INIT     = 4'(INIT_SEC);

  typedef enum logic [1:0] {
    IDLE,
    TURN_A,
    TURN_B,
    TIMEOUT
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          toa_q, toa_d;
  logic          tob_q, tob_d;
  logic          in_turn;
  logic          tick;

  // One-second tick only advances while a turn is running and not paused.
  assign in_turn = (state_q == TURN_A) || (state_q == TURN_B);
  assign tick    = in_turn && !Pausa && (pre_q == PRE_LAST);

  // State register: turn state, prescaler, seconds counter and sticky timeout flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      cnt_q   <= INIT;
      toa_q   <= 1'b0;
      tob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      toa_q   <= toa_d;
      tob_q   <= tob_d;
    end
  end

  // Next-state logic; priority Start > Jugada > tick. Expiry is declared on the tick after the
  // counter reached 0, so the 0 stays on screen for a full second.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    toa_d   = toa_q;
    tob_d   = tob_q;
    if (Start) begin
      state_d = TURN_A;
      cnt_d   = INIT;
      pre_d   = '0;
      toa_d   = 1'b0;
      tob_d   = 1'b0;
    end else if (in_turn) begin
      if (Jugada) begin
        state_d = (state_q == TURN_A) ? TURN_B : TURN_A;
        cnt_d   = INIT;
        pre_d   = '0;
      end else if (tick) begin
        pre_d = '0;
        if (cnt_q == 4'd0) begin
          state_d = TIMEOUT;
          toa_d   = toa_q | (state_q == TURN_A);
          tob_d   = tob_q | (state_q == TURN_B);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end else if (!Pausa) begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // Registered output decode for the renderer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Numero   <= INIT;
      RojoA    <= 1'b0;
      RojoB    <= 1'b0;
      TimeoutA <= 1'b0;
      TimeoutB <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      Numero   <= in_turn ? cnt_q : ((state_q == TIMEOUT) ? 4'd0 : INIT);
      RojoA    <= (state_q == TURN_A) || toa_q;
      RojoB    <= (state_q == TURN_B) || tob_q;
      TimeoutA <= toa_q;
      TimeoutB <= tob_q;
      Busy     <= in_turn;
    end
  end

endmodule
